trace_cmd_sequencer: RTL and testbench

//  Synthesizable replacement for the file-reading trace driver loop.

---
 rtl/trace_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_trace_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_cmd_sequencer.sv
// Trace command sequencer: buffers (cmd, addr) entries, issues cache codes 0-4 via valid/ready,
// pulses clear/print/illegal for the other codes, keeps per-code counters and flags end of trace.
module trace_cmd_sequencer #(
   parameter int ADDR_W = 32,
   parameter int CMD_W  = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 32
) (
   input  logic                     Clock,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CMD_W-1:0]         in_cmd,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic                     trace_end,
   input  logic                     mode,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [CMD_W-1:0]         cmd_out,
   output logic [ADDR_W-1:0]        addr_out,
   output logic                     cache_clear,
   output logic                     print_req,
   output logic                     illegal,
   input  logic [3:0]               count_sel,
   output logic [CNT_W-1:0]         count_out,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     Finish
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {ISSUE, CLEAR_WAIT, DONE} state_t;

   state_t              state;
   logic [CMD_W-1:0]    cmd_mem  [DEPTH];
   logic [ADDR_W-1:0]   addr_mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W:0]      level;
   logic                end_latched;
   // Slots 12-15 are never incremented; they exist so a 4-bit select indexes in range.
   logic [CNT_W-1:0]    cnt [16];

   logic [CMD_W-1:0]    head_cmd;
   logic [ADDR_W-1:0]   head_addr;
   logic                empty;
   logic                full;
   logic                push;
   logic                pop;
   logic                issue;
   logic                is_cache;
   logic                is_clr;
   logic                is_prt;
   logic                is_ill;
   logic [3:0]          cnt_idx;

   assign head_cmd  = cmd_mem[rd_ptr];
   assign head_addr = addr_mem[rd_ptr];
   assign empty     = (level == '0);
   assign full      = (level == (PTR_W+1)'(DEPTH));
   assign in_ready  = !full && !end_latched && (state != DONE);
   assign push      = in_valid && in_ready;

   assign is_cache  = (head_cmd <= CMD_W'(4));
   assign is_clr    = (head_cmd == CMD_W'(8));
   assign is_prt    = (head_cmd == CMD_W'(9));
   assign is_ill    = !(is_cache || is_clr || is_prt);
   assign issue     = (state == ISSUE) && !empty;

   assign cmd_valid   = issue && is_cache;
   assign cmd_out     = cmd_valid ? head_cmd  : '0;
   assign addr_out    = cmd_valid ? head_addr : '0;
   assign cache_clear = issue && is_clr;
   assign print_req   = issue && is_prt && mode;
   assign illegal     = issue && is_ill;

   // Only cache commands wait on the consumer; every other code retires in one cycle.
   assign pop     = issue && (is_cache ? cmd_ready : 1'b1);
   assign cnt_idx = is_ill ? 4'd10 : 4'(head_cmd);

   assign count_out  = (count_sel < 4'd12) ? cnt[count_sel] : '0;
   assign fifo_level = level;
   assign Finish     = (state == DONE);

   always_ff @(posedge Clock) begin
      if (push) begin
         cmd_mem[wr_ptr]  <= in_cmd;
         addr_mem[wr_ptr] <= in_addr;
      end
   end

   always_ff @(posedge Clock) begin
      if (!clear) begin
         state       <= ISSUE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         end_latched <= 1'b0;
         for (int i = 0; i < 16; i++) cnt[i] <= '0;
      end else begin
         if (trace_end) end_latched <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         if (pop) begin
            if (cnt[cnt_idx] != {CNT_W{1'b1}}) cnt[cnt_idx] <= cnt[cnt_idx] + 1'b1;
            if (cnt[11] != {CNT_W{1'b1}})      cnt[11]      <= cnt[11] + 1'b1;
         end

         case (state)
            ISSUE: begin
               if (pop && is_clr)
                  state <= CLEAR_WAIT;
               else if (end_latched && empty && !pop)
                  state <= DONE;
            end
            CLEAR_WAIT: state <= ISSUE;
            DONE:       state <= DONE;
            default:    state <= ISSUE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_cmd_sequencer.sv
// Scoreboard bench for trace_cmd_sequencer: expected cache commands are queued at push
// and compared at each observed handshake; directed checks cover pulses, counters and finish.
module tb_trace_cmd_sequencer;

   logic        Clock;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cmd;
   logic [31:0] in_addr;
   logic        trace_end;
   logic        mode;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_out;
   logic [31:0] addr_out;
   logic        cache_clear;
   logic        print_req;
   logic        illegal;
   logic [3:0]  count_sel;
   logic [31:0] count_out;
   logic [3:0]  fifo_level;
   logic        Finish;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] addr;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   trace_cmd_sequencer #(.ADDR_W(32), .CMD_W(4), .DEPTH(8), .CNT_W(32)) dut (
      .Clock(Clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_cmd(in_cmd), .in_addr(in_addr), .trace_end(trace_end), .mode(mode),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_out(cmd_out), .addr_out(addr_out),
      .cache_clear(cache_clear), .print_req(print_req), .illegal(illegal),
      .count_sel(count_sel), .count_out(count_out), .fifo_level(fifo_level), .Finish(Finish)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every accepted cache command must come out in order with its address.
   always @(negedge Clock) begin
      if (clear && cmd_valid && cmd_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_cmd", 64'(cmd_out), 64'(e.cmd));
            chk("sb_addr", 64'(addr_out), 64'(e.addr));
         end
      end
   end

   task automatic push(input logic [3:0] c, input logic [31:0] a);
      int n = 0;
      in_valid = 1'b1;
      in_cmd   = c;
      in_addr  = a;
      while (!in_ready && n < 50) begin
         @(posedge Clock); #1;
         n++;
      end
      if (!in_ready) chk("push_timeout", 64'(in_ready), 1);
      else if (c <= 4'd4) sb.push_back({c, a});
      @(posedge Clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      clear = 1'b0;
      @(posedge Clock); #1;
      clear = 1'b1;
      sb.delete();
   endtask

   task automatic chk_cnt(input string tag, input logic [3:0] sel, input logic [31:0] exp);
      count_sel = sel;
      #1;
      chk(tag, 64'(count_out), 64'(exp));
   endtask

   initial begin
      int n;
      clear = 1'b0; in_valid = 1'b0; in_cmd = '0; in_addr = '0;
      trace_end = 1'b0; mode = 1'b0; cmd_ready = 1'b0; count_sel = '0;
      repeat (2) @(posedge Clock);
      #1 clear = 1'b1;

      // Reset with three entries held
      for (int i = 0; i < 3; i++) push(4'd1, 32'h100 + 32'(i));
      chk("pre_reset_level", 64'(fifo_level), 3);
      do_reset();
      @(negedge Clock);
      chk("rst_level", 64'(fifo_level), 0);
      chk("rst_cmd_valid", 64'(cmd_valid), 0);
      chk("rst_finish", 64'(Finish), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk_cnt("rst_total", 4'd11, 0);

      // First command, show-ahead issue
      cmd_ready = 1'b1;
      push(4'd0, 32'h1000_0040);
      @(negedge Clock);
      chk("first_valid", 64'(cmd_valid), 1);
      chk("first_cmd", 64'(cmd_out), 0);
      chk("first_addr", 64'(addr_out), 64'h1000_0040);
      @(posedge Clock); #1;
      chk_cnt("first_cnt0", 4'd0, 1);
      chk_cnt("first_total", 4'd11, 1);
      cmd_ready = 1'b0;

      // Backpressure: fill to full, head held
      for (int i = 0; i < 8; i++) push(4'(i % 5), 32'h2000 + 32'(i * 4));
      @(negedge Clock);
      chk("full_level", 64'(fifo_level), 8);
      chk("full_in_ready", 64'(in_ready), 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge Clock);
         chk("hold_cmd", 64'(cmd_out), 0);
         chk("hold_addr", 64'(addr_out), 64'h2000);
      end
      @(posedge Clock); #1;
      cmd_ready = 1'b1;
      @(posedge Clock); #1;
      cmd_ready = 1'b0;
      chk("one_pop_level", 64'(fifo_level), 7);
      chk("one_pop_ready", 64'(in_ready), 1);
      in_valid = 1'b1; in_cmd = 4'd3; in_addr = 32'h2100; cmd_ready = 1'b1;
      sb.push_back({4'd3, 32'h2100});
      @(posedge Clock); #1;
      in_valid = 1'b0; cmd_ready = 1'b0;
      chk("pushpop_level", 64'(fifo_level), 7);
      push(4'd2, 32'h2200);
      chk("refill_level", 64'(fifo_level), 8);
      cmd_ready = 1'b1;
      n = 0;
      while (fifo_level != 0 && n < 100) begin
         @(negedge Clock);
         n++;
      end
      chk("drain_level", 64'(fifo_level), 0);
      chk("drain_sb", 64'(sb.size()), 0);
      cmd_ready = 1'b0;

      // Sequence 1, 8, 2
      push(4'd1, 32'h3000);
      push(4'd8, 32'h0);
      push(4'd2, 32'h3008);
      cmd_ready = 1'b1;
      @(negedge Clock);
      chk("seq_a_valid", 64'(cmd_valid), 1);
      chk("seq_a_cmd", 64'(cmd_out), 1);
      chk("seq_a_clr", 64'(cache_clear), 0);
      @(negedge Clock);
      chk("seq_b_clr", 64'(cache_clear), 1);
      chk("seq_b_valid", 64'(cmd_valid), 0);
      @(negedge Clock);
      chk("seq_c_clr", 64'(cache_clear), 0);
      chk("seq_c_valid", 64'(cmd_valid), 0);
      @(negedge Clock);
      chk("seq_d_valid", 64'(cmd_valid), 1);
      chk("seq_d_cmd", 64'(cmd_out), 2);
      @(negedge Clock);
      chk("seq_e_level", 64'(fifo_level), 0);
      chk_cnt("seq_cnt8", 4'd8, 1);
      cmd_ready = 1'b0;

      // Print / illegal codes from a clean reset
      do_reset();
      mode = 1'b0;
      push(4'd9, 32'h0);
      @(negedge Clock);
      chk("print_silent", 64'(print_req), 0);
      chk("print_no_cmd", 64'(cmd_valid), 0);
      mode = 1'b1;
      push(4'd9, 32'h0);
      @(negedge Clock);
      chk("print_verbose", 64'(print_req), 1);
      push(4'd6, 32'h0);
      @(negedge Clock);
      chk("illegal_pulse", 64'(illegal), 1);
      chk("illegal_no_print", 64'(print_req), 0);
      @(negedge Clock);
      chk("illegal_once", 64'(illegal), 0);
      chk_cnt("cnt9", 4'd9, 2);
      chk_cnt("cnt10", 4'd10, 1);
      chk_cnt("cnt_total", 4'd11, 3);
      chk_cnt("cnt_sel_hi", 4'd13, 0);
      mode = 1'b0;

      // End of trace with the last push
      cmd_ready = 1'b1;
      trace_end = 1'b1;
      push(4'd4, 32'hDEAD_BEEC);
      trace_end = 1'b0;
      @(negedge Clock);
      chk("end_valid", 64'(cmd_valid), 1);
      chk("end_cmd", 64'(cmd_out), 4);
      chk("end_addr", 64'(addr_out), 64'hDEAD_BEEC);
      chk("end_finish_early", 64'(Finish), 0);
      chk("end_in_ready", 64'(in_ready), 0);
      n = 0;
      while (!Finish && n < 6) begin
         @(negedge Clock);
         n++;
      end
      chk("finish_set", 64'(Finish), 1);
      in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h4000;
      repeat (3) @(negedge Clock);
      chk("done_level", 64'(fifo_level), 0);
      chk("done_in_ready", 64'(in_ready), 0);
      chk("done_finish", 64'(Finish), 1);
      chk("done_valid", 64'(cmd_valid), 0);
      in_valid = 1'b0;
      chk_cnt("cnt4", 4'd4, 1);
      do_reset();
      @(negedge Clock);
      chk("post_finish", 64'(Finish), 0);
      chk("post_in_ready", 64'(in_ready), 1);
      chk_cnt("post_cnt4", 4'd4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
